move_controller: RTL and testbench
==================================

// Module: move_controller
// PURPOSE
//  Turns click events from the mouse-to-square stage into validated chess moves.
//  - Sits downstream of the square decoder, which supplies mouse_position, pick_piece and place_piece.
//  - Reads the board RAM to check the source and destination squares.
//  - Emits one move request to the board-update stage using a valid/ready handshake.
//  - Exports the current selection so the renderer can highlight it.
// PARAMETERS
//  BOARD_X0  256  left pixel edge of the board
//  BOARD_Y0  128  top pixel edge of the board
//  SQ_SIZE   64   square edge in pixels; must be a power of two; board is 8*SQ_SIZE wide and tall
//  PIECE_W   4    piece code width; 0 = empty; MSB = colour (0 white, 1 black)
// PORTS
//  clk             in   1        system clock
//  rst             in   1        asynchronous, active-low reset
//  mouse_xpos      in   12       cursor x in pixels
//  mouse_ypos      in   12       cursor y in pixels
//  mouse_position  in   6        square under cursor: [5:3] column, [2:0] row
//  pick_piece      in   1        level from the decoder; toggles on the first click
//  place_piece     in   1        level from the decoder; toggles on the second click
//  sq_addr         out  6        board RAM read address
//  sq_piece        in   PIECE_W  board RAM read data; valid 1 clk after sq_addr
//  move_valid      out  1        move request pending
//  move_ready      in   1        board-update stage accepts the move
//  move_from       out  6        source square
//  move_to         out  6        destination square
//  move_piece      out  PIECE_W  piece being moved
//  sel_active      out  1        a source square is currently selected
//  sel_sq          out  6        selected square, for highlighting
//  turn            out  1        side to move: 0 white, 1 black
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, FSM in IDLE, turn = white, edge registers = 0.
//  Click detection
//   - click = rising edge of pick_piece OR rising edge of place_piece.
//   - Edges come from registered copies of the previous input values.
//   - Both inputs are treated alike, so the FSM cannot desync from the decoder's toggle.
//   - on_board = (BOARD_X0 <= x < BOARD_X0+8*SQ_SIZE) AND (BOARD_Y0 <= y < BOARD_Y0+8*SQ_SIZE).
//   - Compare at 13 bits so there is no unsigned wrap.
//   - mouse_position and on_board are latched in the cycle the click is detected.
//  FSM states: IDLE, SRC_RD, SRC_CHK, HOLD, DST_RD, DST_CHK, REQ.
//   IDLE
//    - click & on_board: latch src = mouse_position, drive sq_addr = src -> SRC_RD.
//    - click off-board: ignored.
//   SRC_RD
//    - Wait one cycle for RAM data -> SRC_CHK.
//   SRC_CHK
//    - sq_piece != 0 and colour == turn: latch piece, sel_active = 1, sel_sq = src -> HOLD.
//    - Otherwise -> IDLE; nothing selected.
//   HOLD
//    - click off-board, or click on dst == src: cancel; sel_active = 0 -> IDLE.
//    - click on any other square: latch dst, sq_addr = dst -> DST_RD.
//   DST_RD
//    - Wait one cycle -> DST_CHK.
//   DST_CHK
//    - sq_piece nonzero with colour == turn (own piece): cancel -> IDLE, sel_active = 0.
//    - Otherwise: move_valid = 1 -> REQ.
//   REQ
//    - move_from, move_to and move_piece are held stable while move_valid = 1.
//    - On move_valid & move_ready: move_valid = 0, sel_active = 0, turn toggles -> IDLE.
//    - Clicks arriving in REQ, SRC_RD, SRC_CHK, DST_RD or DST_CHK are dropped.
//  Timing
//   - Latency click -> move_valid: 4 clk (detect, RD, CHK, REQ entry) when move_ready is already high.
//   - move_ready held high in REQ completes the handshake in one cycle.
//  Other rules
//   - move_ready while not in REQ: ignored.
//   - No chess-rule legality checks beyond colour and capture-own; those belong to a later block.
//   - Reset mid-request: move_valid drops immediately; no partial move is issued.
// TESTING
//  - Reset: drive rst=0 mid-REQ -> move_valid=0, sel_active=0, turn=0, sq_addr=0 at once.
//  - Happy path: click sq 6'o14 (white pawn 4'h1), click sq 6'o34 (empty), move_ready=1 -> one move (14->34, 4'h1), turn=1.
//  - Source checks: click an empty square, or a black piece on white's turn -> stays IDLE, sel_active=0, no request.
//  - Cancel: select 6'o14, then click 6'o14 again or x=100 (off-board) -> IDLE, sel_active=0, turn unchanged.
//  - Capture-own: select 6'o14, click a square holding 4'h2 (white) -> cancel, no request; black target 4'hA -> request issued.
//  - Backpressure: move_ready=0 for 10 clk -> move_valid/from/to/piece stable, extra clicks ignored; ready=1 -> single accept.

Source files
------------

// File: rtl/move_controller.sv
// rtl/move_controller.sv - turns decoder click events into colour-checked chess move requests
module move_controller #(
    parameter int BOARD_X0 = 256,
    parameter int BOARD_Y0 = 128,
    parameter int SQ_SIZE  = 64,
    parameter int PIECE_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        mouse_xpos,
    input  logic [11:0]        mouse_ypos,
    input  logic [5:0]         mouse_position,
    input  logic               pick_piece,
    input  logic               place_piece,
    output logic [5:0]         sq_addr,
    input  logic [PIECE_W-1:0] sq_piece,
    output logic               move_valid,
    input  logic               move_ready,
    output logic [5:0]         move_from,
    output logic [5:0]         move_to,
    output logic [PIECE_W-1:0] move_piece,
    output logic               sel_active,
    output logic [5:0]         sel_sq,
    output logic               turn
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SRC_RD  = 3'd1,
        SRC_CHK = 3'd2,
        HOLD    = 3'd3,
        DST_RD  = 3'd4,
        DST_CHK = 3'd5,
        REQ     = 3'd6
    } state_t;

    localparam logic [12:0] X_LO = 13'(BOARD_X0);
    localparam logic [12:0] X_HI = 13'(BOARD_X0 + 8 * SQ_SIZE);
    localparam logic [12:0] Y_LO = 13'(BOARD_Y0);
    localparam logic [12:0] Y_HI = 13'(BOARD_Y0 + 8 * SQ_SIZE);

    state_t               state_q, state_d;
    logic                 pick_q, pick_d;
    logic                 place_q, place_d;
    logic                 click_q, click_d;
    logic [5:0]           pos_q, pos_d;
    logic                 on_board_q, on_board_d;
    logic [5:0]           src_q, src_d;
    logic [5:0]           dst_q, dst_d;
    logic [PIECE_W-1:0]   piece_q, piece_d;
    logic [5:0]           sq_addr_q, sq_addr_d;
    logic                 move_valid_q, move_valid_d;
    logic [5:0]           move_from_q, move_from_d;
    logic [5:0]           move_to_q, move_to_d;
    logic [PIECE_W-1:0]   move_piece_q, move_piece_d;
    logic                 sel_active_q, sel_active_d;
    logic [5:0]           sel_sq_q, sel_sq_d;
    logic                 turn_q, turn_d;

    logic on_board;
    logic own_piece;
    logic hold_cancel;

    // Widened to 13 bits so the upper bounds cannot wrap.
    assign on_board = ({1'b0, mouse_xpos} >= X_LO) && ({1'b0, mouse_xpos} < X_HI) &&
                      ({1'b0, mouse_ypos} >= Y_LO) && ({1'b0, mouse_ypos} < Y_HI);

    assign own_piece   = (sq_piece != '0) && (sq_piece[PIECE_W-1] == turn_q);
    assign hold_cancel = !on_board_q || (pos_q == src_q);

    always_comb begin
        pick_d     = pick_piece;
        place_d    = place_piece;
        click_d    = (pick_piece & ~pick_q) | (place_piece & ~place_q);
        pos_d      = click_d ? mouse_position : pos_q;
        on_board_d = click_d ? on_board : on_board_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pick_q       <= 1'b0;
            place_q      <= 1'b0;
            click_q      <= 1'b0;
            pos_q        <= '0;
            on_board_q   <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            piece_q      <= '0;
            sq_addr_q    <= '0;
            move_valid_q <= 1'b0;
            move_from_q  <= '0;
            move_to_q    <= '0;
            move_piece_q <= '0;
            sel_active_q <= 1'b0;
            sel_sq_q     <= '0;
            turn_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pick_q       <= pick_d;
            place_q      <= place_d;
            click_q      <= click_d;
            pos_q        <= pos_d;
            on_board_q   <= on_board_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            piece_q      <= piece_d;
            sq_addr_q    <= sq_addr_d;
            move_valid_q <= move_valid_d;
            move_from_q  <= move_from_d;
            move_to_q    <= move_to_d;
            move_piece_q <= move_piece_d;
            sel_active_q <= sel_active_d;
            sel_sq_q     <= sel_sq_d;
            turn_q       <= turn_d;
        end
    end

    // Clicks outside IDLE and HOLD fall through without effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (click_q && on_board_q) state_d = SRC_RD;
            SRC_RD:  state_d = SRC_CHK;
            SRC_CHK: state_d = own_piece ? HOLD : IDLE;
            HOLD:    if (click_q) state_d = hold_cancel ? IDLE : DST_RD;
            DST_RD:  state_d = DST_CHK;
            DST_CHK: state_d = own_piece ? IDLE : REQ;
            REQ:     if (move_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_d        = src_q;
        dst_d        = dst_q;
        piece_d      = piece_q;
        sq_addr_d    = sq_addr_q;
        move_valid_d = move_valid_q;
        move_from_d  = move_from_q;
        move_to_d    = move_to_q;
        move_piece_d = move_piece_q;
        sel_active_d = sel_active_q;
        sel_sq_d     = sel_sq_q;
        turn_d       = turn_q;
        case (state_q)
            IDLE: begin
                if (click_q && on_board_q) begin
                    src_d     = pos_q;
                    sq_addr_d = pos_q;
                end
            end
            SRC_CHK: begin
                if (own_piece) begin
                    piece_d      = sq_piece;
                    sel_active_d = 1'b1;
                    sel_sq_d     = src_q;
                end
            end
            HOLD: begin
                if (click_q) begin
                    if (hold_cancel) begin
                        sel_active_d = 1'b0;
                    end else begin
                        dst_d     = pos_q;
                        sq_addr_d = pos_q;
                    end
                end
            end
            DST_CHK: begin
                if (own_piece) begin
                    sel_active_d = 1'b0;
                end else begin
                    move_valid_d = 1'b1;
                    move_from_d  = src_q;
                    move_to_d    = dst_q;
                    move_piece_d = piece_q;
                end
            end
            REQ: begin
                if (move_ready) begin
                    move_valid_d = 1'b0;
                    sel_active_d = 1'b0;
                    turn_d       = ~turn_q;
                end
            end
            default: ;
        endcase
    end

    assign sq_addr    = sq_addr_q;
    assign move_valid = move_valid_q;
    assign move_from  = move_from_q;
    assign move_to    = move_to_q;
    assign move_piece = move_piece_q;
    assign sel_active = sel_active_q;
    assign sel_sq     = sel_sq_q;
    assign turn       = turn_q;

endmodule

// File: tb/tb_move_controller.sv
// tb/tb_move_controller.sv - directed bench for move_controller with a registered board RAM model
module tb_move_controller;

    logic        clk;
    logic        rst;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [5:0]  mouse_position;
    logic        pick_piece;
    logic        place_piece;
    logic [5:0]  sq_addr;
    logic [3:0]  sq_piece;
    logic        move_valid;
    logic        move_ready;
    logic [5:0]  move_from;
    logic [5:0]  move_to;
    logic [3:0]  move_piece;
    logic        sel_active;
    logic [5:0]  sel_sq;
    logic        turn;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] board [64];
    int         acc_cnt = 0;
    logic [5:0] acc_from;
    logic [5:0] acc_to;
    logic [3:0] acc_piece;

    move_controller dut (
        .clk            (clk),
        .rst            (rst),
        .mouse_xpos     (mouse_xpos),
        .mouse_ypos     (mouse_ypos),
        .mouse_position (mouse_position),
        .pick_piece     (pick_piece),
        .place_piece    (place_piece),
        .sq_addr        (sq_addr),
        .sq_piece       (sq_piece),
        .move_valid     (move_valid),
        .move_ready     (move_ready),
        .move_from      (move_from),
        .move_to        (move_to),
        .move_piece     (move_piece),
        .sel_active     (sel_active),
        .sel_sq         (sel_sq),
        .turn           (turn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        sq_piece <= board[sq_addr];
        if (rst && move_valid && move_ready) begin
            acc_cnt   <= acc_cnt + 1;
            acc_from  <= move_from;
            acc_to    <= move_to;
            acc_piece <= move_piece;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_mouse(input logic [5:0] sq, input bit onb);
        mouse_position = sq;
        if (onb) begin
            mouse_xpos = 12'(256 + int'(sq[5:3]) * 64 + 32);
            mouse_ypos = 12'(128 + int'(sq[2:0]) * 64 + 32);
        end else begin
            mouse_xpos = 12'd100;
            mouse_ypos = 12'd200;
        end
    endtask

    task automatic click(input logic [5:0] sq, input bit onb, input bit use_place);
        @(negedge clk);
        set_mouse(sq, onb);
        if (use_place) place_piece = 1'b1; else pick_piece = 1'b1;
        repeat (2) @(negedge clk);
        if (use_place) place_piece = 1'b0; else pick_piece = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int lat;
        bit stable;

        for (int i = 0; i < 64; i++) board[i] = 4'h0;
        board[6'o14] = 4'h1;
        board[6'o24] = 4'h2;
        board[6'o44] = 4'hA;
        board[6'o60] = 4'h9;
        sq_piece = 4'h0;

        rst = 1'b0;
        pick_piece = 1'b0;
        place_piece = 1'b0;
        move_ready = 1'b1;
        set_mouse(6'o00, 1'b1);
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(move_valid), 32'd0);
        chk("reset_sel", 32'(sel_active), 32'd0);
        chk("reset_turn", 32'(turn), 32'd0);
        chk("reset_addr", 32'(sq_addr), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // empty source square
        click(6'o34, 1'b1, 1'b0);
        chk("src_empty_sel", 32'(sel_active), 32'd0);
        chk("src_empty_addr", 32'(sq_addr), 32'o34);
        // black piece on white's turn
        click(6'o60, 1'b1, 1'b0);
        chk("src_black_sel", 32'(sel_active), 32'd0);

        // select then reclick same square
        click(6'o14, 1'b1, 1'b0);
        chk("sel_active", 32'(sel_active), 32'd1);
        chk("sel_sq", 32'(sel_sq), 32'o14);
        click(6'o14, 1'b1, 1'b1);
        chk("cancel_same_sel", 32'(sel_active), 32'd0);
        chk("cancel_same_turn", 32'(turn), 32'd0);

        // select then click off-board
        click(6'o14, 1'b1, 1'b0);
        click(6'o14, 1'b0, 1'b1);
        chk("cancel_off_sel", 32'(sel_active), 32'd0);

        // capture own piece
        click(6'o14, 1'b1, 1'b0);
        click(6'o24, 1'b1, 1'b1);
        chk("own_cap_sel", 32'(sel_active), 32'd0);
        chk("own_cap_none", 32'(acc_cnt), 32'd0);
        chk("own_cap_valid", 32'(move_valid), 32'd0);

        // happy path with latency measurement
        click(6'o14, 1'b1, 1'b0);
        @(negedge clk);
        set_mouse(6'o34, 1'b1);
        place_piece = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) place_piece = 1'b0;
            if (move_valid && lat == 0) lat = k;
        end
        chk("happy_latency", 32'(lat), 32'd4);
        chk("happy_count", 32'(acc_cnt), 32'd1);
        chk("happy_from", 32'(acc_from), 32'o14);
        chk("happy_to", 32'(acc_to), 32'o34);
        chk("happy_piece", 32'(acc_piece), 32'h1);
        chk("happy_turn", 32'(turn), 32'd1);
        chk("happy_sel", 32'(sel_active), 32'd0);

        // black captures white under backpressure
        move_ready = 1'b0;
        click(6'o60, 1'b1, 1'b0);
        chk("bp_sel", 32'(sel_active), 32'd1);
        click(6'o24, 1'b1, 1'b1);
        chk("bp_valid", 32'(move_valid), 32'd1);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 2) begin set_mouse(6'o00, 1'b1); pick_piece = 1'b1; end
            if (k == 4) pick_piece = 1'b0;
            if (k == 5) begin set_mouse(6'o14, 1'b1); place_piece = 1'b1; end
            if (k == 7) place_piece = 1'b0;
            if (!(move_valid === 1'b1 && move_from === 6'o60 && move_to === 6'o24 &&
                  move_piece === 4'h9 && sel_active === 1'b1))
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_no_accept", 32'(acc_cnt), 32'd1);
        move_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_count", 32'(acc_cnt), 32'd2);
        chk("bp_accept_to", 32'(acc_to), 32'o24);
        chk("bp_valid_drop", 32'(move_valid), 32'd0);
        chk("bp_turn", 32'(turn), 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_single", 32'(acc_cnt), 32'd2);

        // white captures black, then reset mid-request
        move_ready = 1'b0;
        click(6'o14, 1'b1, 1'b0);
        click(6'o44, 1'b1, 1'b1);
        chk("cap_black_valid", 32'(move_valid), 32'd1);
        chk("cap_black_to", 32'(move_to), 32'o44);
        chk("cap_black_sq_addr", 32'(sq_addr), 32'o44);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(move_valid), 32'd0);
        chk("rst_mid_sel", 32'(sel_active), 32'd0);
        chk("rst_mid_turn", 32'(turn), 32'd0);
        chk("rst_mid_addr", 32'(sq_addr), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_no_partial", 32'(acc_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
